mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbitrates one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipelined MIPS core. It grants one requester at a time, sequences the memory handshake, returns read data and a one-cycle done pulse, and drives per-stage stall signals into the pipeline hazard logic. Data accesses have priority, and a starvation guard keeps fetch from being locked out. A timeout aborts an access if the memory never answers.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced (1..15)
TIMEOUT, 16, max cycles in ISSUE awaiting mem_ready before abort (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; level, held until if_done
if_addr  in  ADDR_W  fetch address; stable while if_req
if_rdata  out  DATA_W  fetched instruction; registered
if_done  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request; level, held until dm_done
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data; registered
dm_done  out  1  one-cycle completion pulse for data
err  out  1  high with a done pulse when that access timed out
stall_if  out  1  if_req & ~if_done
stall_mem  out  1  dm_req & ~dm_done
mem_en  out  1  memory command valid; registered
mem_we  out  1  memory write enable; registered
mem_addr  out  ADDR_W  memory address; registered
mem_wdata  out  DATA_W  memory write data; registered
mem_rdata  in  DATA_W  memory read data; valid when mem_ready=1
mem_ready  in  1  memory completion strobe, 1 cycle

Behaviour:
- Reset (async, immediate): state=IDLE; mem_en, mem_we, if_done, dm_done, err=0; mem_addr, mem_wdata, if_rdata, dm_rdata=0; starve_cnt=0; tmo_cnt=0. Reset mid-access drops mem_en at once and loses the access. The requester re-requests after reset.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - With no request, stay in IDLE.
  - With any request, pick a winner, latch owner, and on the next edge load mem_en=1, mem_we (dm_we for data, 0 for fetch), mem_addr, mem_wdata. Go to ISSUE with tmo_cnt=0.
- Winner rule:
  - Only one request: that requester wins.
  - Both requesting: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
  - On a data grant with if_req=1, starve_cnt increments and saturates at STARVE_MAX.
  - On any fetch grant, starve_cnt clears.
- ISSUE:
  - mem_* are held constant; tmo_cnt increments each cycle.
  - If mem_ready is sampled 1: capture mem_rdata into the owner's rdata register (fetch, or data on a load; dm_rdata is unchanged on a store). Pulse the owner's done for 1 cycle, err=0, mem_en=0, go to DONE.
  - Else if tmo_cnt==TIMEOUT-1: abort. Owner's rdata=0, owner's done=1, err=1, mem_en=0, go to DONE.
  - mem_ready while in IDLE or DONE is ignored.
- DONE: exactly one cycle, always goes to IDLE. It grants nothing, so a request still high during the done cycle is not re-granted.
- Latency: request seen in IDLE at cycle 0 gives mem_en=1 at cycle 1. With mem_ready at cycle 1, done is at cycle 2 and IDLE returns at cycle 3. Minimum issue interval is 3 cycles per access.
- if_done and dm_done are never high together; err is 0 whenever both done signals are 0.
- stall_if and stall_mem are combinational from inputs and registered done signals only, so there is no combinational path from mem_ready.
- Requests that drop while in ISSUE do not cancel the access; it completes or times out normally.

Test Plan:
- Fetch only: if_addr=0x0, memory answers mem_ready one cycle after mem_en with 0x00221820 -> mem_en at cycle 1 with mem_addr=0x0 and mem_we=0; if_done and if_rdata=0x00221820 at cycle 2; stall_if high cycles 0-1.
- Store: dm_req, dm_we=1, dm_addr=0x8, dm_wdata=0x5 -> mem_we=1, mem_addr=0x8, mem_wdata=0x5; dm_done pulses; dm_rdata keeps its prior value; err=0.
- Simultaneous requests held continuously, STARVE_MAX=4 -> grant order D,D,D,D,F,D,...; starve_cnt reaches 4 and then clears on the fetch grant.
- Timeout: load to 0x4, mem_ready never asserted, TIMEOUT=16 -> mem_en high exactly 16 cycles, then dm_done=1, err=1, dm_rdata=0, then IDLE.
- Reset mid-ISSUE: assert reset between clock edges with mem_en=1 -> mem_en, done and err go 0 immediately; after release, state is IDLE and a held if_req is re-granted 1 cycle later.
- Back-to-back loads with dm_req held across dm_done -> no grant during the DONE cycle; the second mem_en rises exactly 2 cycles after the first dm_done.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the arbiter and the unified memory.
// slave is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_done;
   logic              err;
   logic              stall_if;
   logic              stall_mem;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_rdata, if_done, dm_rdata, dm_done, err, stall_if, stall_mem,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_done, dm_rdata, dm_done, err, stall_if, stall_mem,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with data
// priority, a fetch starvation guard and an access timeout.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic               clk,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;     // 1 = data access owns the port
   logic [3:0]        starve_q, starve_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_done_q, if_done_d;
   logic              dm_done_q, dm_done_d;
   logic              err_q, err_d;
   logic              grant_dm;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         starve_q    <= '0;
         tmo_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_done_q   <= 1'b0;
         dm_done_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_done_q   <= if_done_d;
         dm_done_q   <= dm_done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      starve_d    = starve_q;
      tmo_d       = tmo_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_done_d   = 1'b0;
      dm_done_d   = 1'b0;
      err_d       = 1'b0;
      // Fetch only wins a contested cycle once it has been passed over STARVE_MAX times.
      grant_dm    = bus.dm_req & ~(bus.if_req & (starve_q == 4'(STARVE_MAX)));

      unique case (state_q)
         IDLE: begin
            if (bus.if_req || bus.dm_req) begin
               state_d     = ISSUE;
               owner_d     = grant_dm;
               tmo_d       = '0;
               mem_en_d    = 1'b1;
               mem_we_d    = grant_dm & bus.dm_we;
               mem_addr_d  = grant_dm ? bus.dm_addr  : bus.if_addr;
               mem_wdata_d = grant_dm ? bus.dm_wdata : '0;
               if (!grant_dm)
                  starve_d = '0;
               else if (bus.if_req && starve_q != 4'(STARVE_MAX))
                  starve_d = starve_q + 4'd1;
            end
         end
         ISSUE: begin
            tmo_d = tmo_q + TW'(1);
            if (bus.mem_ready) begin
               state_d  = DONE;
               mem_en_d = 1'b0;
               if (owner_q) begin
                  dm_done_d = 1'b1;
                  if (!mem_we_q) dm_rdata_d = bus.mem_rdata;
               end else begin
                  if_done_d  = 1'b1;
                  if_rdata_d = bus.mem_rdata;
               end
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               state_d  = DONE;
               mem_en_d = 1'b0;
               err_d    = 1'b1;
               if (owner_q) begin
                  dm_done_d  = 1'b1;
                  dm_rdata_d = '0;
               end else begin
                  if_done_d  = 1'b1;
                  if_rdata_d = '0;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.dm_done   = dm_done_q;
   assign bus.err       = err_q;
   // Stalls use registered done only, keeping mem_ready out of the hazard path.
   assign bus.stall_if  = bus.if_req & ~if_done_q;
   assign bus.stall_mem = bus.dm_req & ~dm_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a small memory model answers mem_en, and
// expected completions are queued at request time and matched on done pulses.
module tb_mem_port_arbiter;
   logic clk;
   logic reset;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit          data;
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] mem_arr [0:63];
   logic [31:0] dm_last  = 32'h0;
   bit          resp_on  = 1'b1;
   int          lat      = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Memory model: answers once per mem_en assertion after lat extra cycles.
   initial begin : responder
      int  wcnt;
      bit  served;
      wcnt = 0;
      served = 1'b0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         bus.mem_ready = 1'b0;
         if (!bus.mem_en) begin
            served = 1'b0;
            wcnt   = 0;
         end else if (resp_on && !served) begin
            if (wcnt >= lat) begin
               bus.mem_ready = 1'b1;
               served = 1'b1;
               if (bus.mem_we) mem_arr[bus.mem_addr[7:2]] = bus.mem_wdata;
               else            bus.mem_rdata = mem_arr[bus.mem_addr[7:2]];
            end else begin
               wcnt++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.if_done || bus.dm_done) begin
            chk("done_excl", 32'(bus.if_done & bus.dm_done), 32'd0);
            if (sbq.size() == 0) begin
               chk("unexp_done", 32'd1, 32'd0);
            end else begin
               mon_e = sbq.pop_front();
               chk("sb_owner", 32'(bus.dm_done), 32'(mon_e.data));
               chk("sb_rdata", mon_e.data ? bus.dm_rdata : bus.if_rdata, mon_e.rdata);
               chk("sb_err", 32'(bus.err), 32'(mon_e.err));
            end
         end else if (bus.err) begin
            chk("err_no_done", 32'(bus.err), 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Returns at the negedge of the done cycle.
   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus.if_done || bus.dm_done) && n < 64);
      if (!(bus.if_done || bus.dm_done)) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_req(input bit data, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
      exp_t e;
      e.data = data;
      e.err  = 1'b0;
      if (data && we) e.rdata = dm_last;
      else            e.rdata = mem_arr[addr[7:2]];
      if (data && !we) dm_last = e.rdata;
      if (data && we)  mem_arr[addr[7:2]] = wdata;
      sbq.push_back(e);
      if (data) begin
         bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
      end else begin
         bus.if_req = 1'b1; bus.if_addr = addr;
      end
      @(negedge clk);
      @(negedge clk);
      chk("req_mem_en", 32'(bus.mem_en), 32'd1);
      chk("req_mem_we", 32'(bus.mem_we), 32'(data & we));
      chk("req_mem_addr", bus.mem_addr, addr);
      if (data && we) chk("req_mem_wdata", bus.mem_wdata, wdata);
      wait_done();
      tick();
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      exp_t e;
      int   cnt, n, nd, nf;
      for (int i = 0; i < 64; i++) mem_arr[i] = 32'hA500_0000 + 32'(i * 3);
      mem_arr[0] = 32'h0022_1820;
      reset = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      tick(); tick();
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_if_done", 32'(bus.if_done), 32'd0);
      chk("rst_dm_done", 32'(bus.dm_done), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_if_rdata", bus.if_rdata, 32'd0);
      chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
      reset = 1'b0;
      tick();

      // Fetch with cycle-exact latency
      lat = 0;
      e.data = 1'b0; e.rdata = 32'h0022_1820; e.err = 1'b0;
      sbq.push_back(e);
      bus.if_req = 1'b1; bus.if_addr = 32'h0;
      @(negedge clk);
      chk("f_c0_stall_if", 32'(bus.stall_if), 32'd1);
      chk("f_c0_mem_en", 32'(bus.mem_en), 32'd0);
      @(negedge clk);
      chk("f_c1_mem_en", 32'(bus.mem_en), 32'd1);
      chk("f_c1_mem_addr", bus.mem_addr, 32'h0);
      chk("f_c1_mem_we", 32'(bus.mem_we), 32'd0);
      chk("f_c1_stall_if", 32'(bus.stall_if), 32'd1);
      @(negedge clk);
      chk("f_c2_if_done", 32'(bus.if_done), 32'd1);
      chk("f_c2_if_rdata", bus.if_rdata, 32'h0022_1820);
      chk("f_c2_stall_if", 32'(bus.stall_if), 32'd0);
      chk("f_c2_mem_en", 32'(bus.mem_en), 32'd0);
      tick();
      bus.if_req = 1'b0;

      // Load, store (dm_rdata must hold the load value), then load back the stored word
      do_req(1'b1, 1'b0, 32'h8, 32'h0);
      do_req(1'b1, 1'b1, 32'h8, 32'h5);
      chk("st_dm_rdata_kept", bus.dm_rdata, mem_arr[0] == 32'h0 ? 32'h0 : dm_last);
      do_req(1'b1, 1'b0, 32'h8, 32'h0);
      chk("ld_after_st", dm_last, 32'h5);

      // Timeout on a load
      resp_on = 1'b0;
      e.data = 1'b1; e.rdata = 32'h0; e.err = 1'b1;
      sbq.push_back(e);
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h4;
      cnt = 0; n = 0;
      do begin
         @(negedge clk);
         n++;
         if (bus.mem_en) cnt++;
      end while (!bus.dm_done && n < 40);
      chk("tmo_mem_en_cycles", 32'(cnt), 32'd16);
      chk("tmo_seen_done", 32'(bus.dm_done), 32'd1);
      dm_last = 32'h0;
      tick();
      bus.dm_req = 1'b0;
      resp_on = 1'b1;
      tick();

      // Contended requests: D,D,D,D,F,D
      lat = 0;
      for (int i = 0; i < 6; i++) begin
         e.err  = 1'b0;
         e.data = (i != 4);
         e.rdata = (i != 4) ? mem_arr[3] : mem_arr[4];
         sbq.push_back(e);
      end
      dm_last = mem_arr[3];
      bus.if_req = 1'b1; bus.if_addr = 32'h10;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'hC;
      nd = 0; nf = 0; n = 0;
      while ((nd < 5 || nf < 1) && n < 200) begin
         @(negedge clk);
         n++;
         if (bus.dm_done) nd++;
         if (bus.if_done) nf++;
         tick();
         if (nf >= 1) bus.if_req = 1'b0;
         if (nd >= 5) bus.dm_req = 1'b0;
      end
      chk("starve_dm_count", 32'(nd), 32'd5);
      chk("starve_if_count", 32'(nf), 32'd1);
      tick();

      // Reset in the middle of an access
      lat = 5;
      e.data = 1'b0; e.rdata = mem_arr[0]; e.err = 1'b0;
      sbq.push_back(e);
      bus.if_req = 1'b1; bus.if_addr = 32'h0;
      @(negedge clk);
      @(negedge clk);
      chk("rmid_mem_en_before", 32'(bus.mem_en), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rmid_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rmid_if_done", 32'(bus.if_done), 32'd0);
      chk("rmid_err", 32'(bus.err), 32'd0);
      chk("rmid_dm_rdata", bus.dm_rdata, 32'd0);
      dm_last = 32'h0;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rrel_idle_mem_en", 32'(bus.mem_en), 32'd0);
      @(negedge clk);
      chk("rrel_regrant", 32'(bus.mem_en), 32'd1);
      wait_done();
      tick();
      bus.if_req = 1'b0;

      // Back-to-back loads with dm_req held across the first done
      lat = 0;
      e.data = 1'b1; e.err = 1'b0;
      e.rdata = mem_arr[5]; sbq.push_back(e);
      e.rdata = mem_arr[6]; sbq.push_back(e);
      dm_last = mem_arr[6];
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h14;
      wait_done();
      bus.dm_addr = 32'h18;
      @(negedge clk);
      chk("b2b_no_grant_p1", 32'(bus.mem_en), 32'd0);
      @(negedge clk);
      chk("b2b_grant_p2", 32'(bus.mem_en), 32'd1);
      chk("b2b_addr", bus.mem_addr, 32'h18);
      wait_done();
      tick();
      bus.dm_req = 1'b0;

      // Randomised single-requester mix with varying memory latency
      for (int i = 0; i < 8; i++) begin
         lat = int'($urandom_range(0, 3));
         do_req(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))),
                {24'h0, 4'($urandom_range(0, 15)), 4'h0}, $urandom);
      end
      tick();
      tick();
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
